// File: rtl/fma_norm_stage.sv
// Two-stage normalizer behind the FMA adder: stage A registers operands plus leading-zero count,
// stage B shifts to left-justify (bounded by EMIN) and registers the result for rounding.
module fma_norm_stage #(
   parameter int unsigned ADDER_WIDTH = 76,
   parameter int unsigned EXP_WIDTH   = 10,
   parameter int          EMIN        = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDER_WIDTH-1:0] sum,
   input  logic                   cout,
   input  logic [EXP_WIDTH-1:0]   exp_in,
   input  logic                   sign_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDER_WIDTH-1:0] mant_out,
   output logic [EXP_WIDTH:0]     exp_out,
   output logic                   sign_out,
   output logic                   sticky_out,
   output logic                   zero_out,
   output logic                   denorm_out
);

   localparam int unsigned LzcW = $clog2(ADDER_WIDTH + 1);
   localparam int unsigned XW   = EXP_WIDTH + 1;
   localparam int unsigned DW   = ((EXP_WIDTH > LzcW) ? EXP_WIDTH : LzcW) + 2;

   logic                   va_q, va_d, vb_q, vb_d;
   logic                   adv_a, adv_b;
   logic                   cout_a_q, cout_a_d, sign_a_q, sign_a_d;
   logic [ADDER_WIDTH-1:0] sum_a_q, sum_a_d;
   logic [EXP_WIDTH-1:0]   exp_a_q, exp_a_d;
   logic [LzcW-1:0]        lzc_a_q, lzc_a_d, lzc;

   logic [ADDER_WIDTH-1:0] mant_q, mant_d;
   logic [XW-1:0]          exp_q, exp_d;
   logic                   sign_q, sign_d, sticky_q, sticky_d;
   logic                   zero_q, zero_d, denorm_q, denorm_d;

   logic signed [DW-1:0]   e_ext, lzc_ext, emin_ext, room;
   logic [XW-1:0]          e_x;
   logic [LzcW-1:0]        shamt;

   assign adv_b    = !vb_q || out_ready;
   assign adv_a    = !va_q || adv_b;
   assign in_ready = adv_a;

   // Ascending scan: the last hit is the most significant set bit.
   always_comb begin
      lzc = LzcW'(ADDER_WIDTH);
      for (int i = 0; i < int'(ADDER_WIDTH); i++) begin
         if (sum[i]) lzc = LzcW'(int'(ADDER_WIDTH) - 1 - i);
      end
   end

   always_comb begin
      va_d     = va_q;
      cout_a_d = cout_a_q;
      sum_a_d  = sum_a_q;
      exp_a_d  = exp_a_q;
      sign_a_d = sign_a_q;
      lzc_a_d  = lzc_a_q;
      if (adv_a) va_d = in_valid;
      if (in_valid && adv_a) begin
         cout_a_d = cout;
         sum_a_d  = sum;
         exp_a_d  = exp_in;
         sign_a_d = sign_in;
         lzc_a_d  = lzc;
      end
   end

   // room = how far the exponent may drop before hitting EMIN.
   always_comb begin
      e_ext    = {{(DW - EXP_WIDTH){exp_a_q[EXP_WIDTH-1]}}, exp_a_q};
      lzc_ext  = {{(DW - LzcW){1'b0}}, lzc_a_q};
      emin_ext = DW'(EMIN);
      room     = e_ext - emin_ext;
      e_x      = {exp_a_q[EXP_WIDTH-1], exp_a_q};
      if (room >= lzc_ext) begin
         shamt = lzc_a_q;
      end else if (!room[DW-1] && (room != '0)) begin
         shamt = room[LzcW-1:0];
      end else begin
         shamt = '0;
      end
   end

   always_comb begin
      vb_d     = vb_q;
      mant_d   = mant_q;
      exp_d    = exp_q;
      sign_d   = sign_q;
      sticky_d = sticky_q;
      zero_d   = zero_q;
      denorm_d = denorm_q;
      if (adv_b) vb_d = va_q;
      if (va_q && adv_b) begin
         sign_d   = sign_a_q;
         sticky_d = 1'b0;
         zero_d   = 1'b0;
         denorm_d = 1'b0;
         if (cout_a_q) begin
            mant_d   = {1'b1, sum_a_q[ADDER_WIDTH-1:1]};
            sticky_d = sum_a_q[0];
            exp_d    = e_x + XW'(1);
         end else if (sum_a_q == '0) begin
            mant_d = '0;
            exp_d  = '0;
            zero_d = 1'b1;
         end else begin
            mant_d   = sum_a_q << shamt;
            exp_d    = e_x - XW'(shamt);
            denorm_d = shamt < lzc_a_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         va_q     <= 1'b0;
         vb_q     <= 1'b0;
         cout_a_q <= 1'b0;
         sum_a_q  <= '0;
         exp_a_q  <= '0;
         sign_a_q <= 1'b0;
         lzc_a_q  <= '0;
         mant_q   <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         sticky_q <= 1'b0;
         zero_q   <= 1'b0;
         denorm_q <= 1'b0;
      end else begin
         va_q     <= va_d;
         vb_q     <= vb_d;
         cout_a_q <= cout_a_d;
         sum_a_q  <= sum_a_d;
         exp_a_q  <= exp_a_d;
         sign_a_q <= sign_a_d;
         lzc_a_q  <= lzc_a_d;
         mant_q   <= mant_d;
         exp_q    <= exp_d;
         sign_q   <= sign_d;
         sticky_q <= sticky_d;
         zero_q   <= zero_d;
         denorm_q <= denorm_d;
      end
   end

   assign out_valid  = vb_q;
   assign mant_out   = mant_q;
   assign exp_out    = exp_q;
   assign sign_out   = sign_q;
   assign sticky_out = sticky_q;
   assign zero_out   = zero_q;
   assign denorm_out = denorm_q;

endmodule

// File: doc/fma_norm_stage.md
Name: fma_norm_stage

Overview:
- Two-stage pipelined normalizer that sits directly downstream of the FMA carry-lookahead adder.
- Consumes the adder's sum and carry-out together with the pre-computed result exponent and sign.
- Produces a left-justified mantissa, the adjusted exponent and zero/denormal/sticky flags for the rounding stage.
- Valid/ready handshake on both sides; full throughput when not stalled.

Parameters:
- ADDER_WIDTH, 76, width of sum input and of mantissa output (value shared from parameters.v).
- EXP_WIDTH, 10, width of signed two's-complement exp_in; exp_out is EXP_WIDTH+1 bits.
- EMIN, 1, smallest normal exponent; left shifts never take exp_out below EMIN.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds valid operands.
- in_ready  out  1  block accepts operands this cycle.
- sum  in  ADDER_WIDTH  adder sum, unsigned magnitude.
- cout  in  1  adder carry-out, weight 2^ADDER_WIDTH relative to the sum LSB.
- exp_in  in  EXP_WIDTH  signed exponent of sum bit ADDER_WIDTH-1.
- sign_in  in  1  result sign, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- mant_out  out  ADDER_WIDTH  normalized mantissa.
- exp_out  out  EXP_WIDTH+1  signed adjusted exponent.
- sign_out  out  1  result sign.
- sticky_out  out  1  OR of bits shifted out on the right.
- zero_out  out  1  result is exactly zero.
- denorm_out  out  1  shift was limited by EMIN, so the result is not left-justified.

Behaviour:
- Reset (async, immediate on rst rising): both stage valid bits cleared and all data registers cleared. out_valid=0, mant_out=0, exp_out=0, sign_out=0, sticky_out=0, zero_out=0, denorm_out=0, in_ready=1.
- Stage A:
  - Captures cout, sum, exp_in and sign_in on acceptance (in_valid & in_ready).
  - Also registers the leading-zero count lzc of sum (0..ADDER_WIDTH; lzc=ADDER_WIDTH when sum==0).
- Stage B: computes the result from Stage A registers and registers it. Output registers drive the ports directly.
- Result rules, with E = exp_in sign-extended to EXP_WIDTH+1:
  - cout=1: mant = {1, sum[W-1:1]}, sticky = sum[0], exp = E+1, zero=0, denorm=0.
  - cout=0, sum!=0: shift s = lzc if E-lzc >= EMIN; otherwise s = max(E-EMIN, 0) and denorm=1.
    - mant = sum << s, exp = E-s, sticky=0.
    - denorm=1 whenever s<lzc, including the case E<EMIN where s=0.
  - cout=0, sum==0: zero=1, mant=0, exp=0, sticky=0, denorm=0. sign still passed through.
- Latency: 2 cycles from acceptance to out_valid, with no stall.
- Handshake:
  - advB = !vB | out_ready. advA = !vA | advB. in_ready = advA (combinational from out_ready).
  - Result transfers on out_valid & out_ready.
  - While out_valid=1 & out_ready=0, all outputs are held stable.
- Simultaneous accept and consume in the same cycle is lossless; back-to-back throughput is 1 per cycle.
- Under stall the pipeline holds 2 items, and in_ready=0 while both stages are full and out_ready=0.
- Order is preserved; no drop or duplicate.
- Values presented on sum, cout, exp_in or sign_in while in_valid=0 are ignored.
- rst mid-operation discards all in-flight items. First acceptance is allowed on the first clk edge after rst deasserts.

Test Plan:
- Bench configuration for all scenarios: ADDER_WIDTH=8, EXP_WIDTH=6, EMIN=1, out_ready=1 unless stated.
- Carry-out: cout=1, sum=8'b10100011, exp_in=5 -> 2 cycles later mant_out=8'b11010001, sticky_out=1, exp_out=6, zero_out=0, denorm_out=0.
- Normal shift: cout=0, sum=8'b00010110, exp_in=10 -> mant_out=8'b10110000, exp_out=7, sticky_out=0, denorm_out=0.
- EMIN clamp: cout=0, sum=8'b00000101, exp_in=3 -> lzc=5, s=2, mant_out=8'b00010100, exp_out=1, denorm_out=1. Second case exp_in=0, same sum -> mant_out=8'b00000101, exp_out=0, denorm_out=1.
- Zero: cout=0, sum=0, exp_in=12, sign_in=1 -> zero_out=1, mant_out=0, exp_out=0, sign_out=1.
- Backpressure: stream 4 distinct items with out_ready=0 for 4 cycles, then 1.
  - in_ready falls after 2 items are accepted.
  - Outputs hold stable during the stall.
  - All 4 results emerge in order, one per cycle once released.
- Reset mid-flight: with both stages valid, assert rst asynchronously between edges -> out_valid=0 and in_ready=1 immediately. No stale result appears after rst deasserts.
